// File: rtl/weight_read_seq.sv
// ---------------------------------------------------------------------------
// weight_read_seq
//   Sequences one pass of numWeight reads from a neuron's weight memory and
//   pairs each returned weight with the input activation that triggered the
//   read. Reads only happen while in_valid is high, so the pass tolerates an
//   arbitrary stall pattern on the activation stream.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a pass (accepted in IDLE and in DONE)
//   abort        : cancel the current pass; wins over start and in_valid
//   in_valid     : in_data carries an activation this cycle
//   in_data      : input activation
//   ren, radd    : weight-memory read enable / address (ren is combinational)
//   pair_valid   : memory output word and x_out form a pair this cycle
//   x_out        : activation delayed to line up with the 1-cycle memory read
//   last         : qualifies the final pair of a pass
//   busy         : sequencer is not idle
//   done         : one-cycle pulse at the end of a completed pass
// ---------------------------------------------------------------------------
module weight_read_seq #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    ren,
  output logic [addressWidth-1:0] radd,
  output logic                    pair_valid,
  output logic [dataWidth-1:0]    x_out,
  output logic                    last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] radd_q, radd_d;
  logic                    pair_valid_q, pair_valid_d;
  logic [dataWidth-1:0]    x_out_q, x_out_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    last_read;

  // A read is issued only when an activation is present; otherwise radd holds.
  assign ren       = (state_q == RUN) && in_valid;
  assign last_read = ren && (radd_q == LAST_ADDR);

  always_comb begin
    state_d      = state_q;
    radd_d       = radd_q;
    // Pair signals trail the read by exactly one cycle (memory latency).
    pair_valid_d = ren;
    last_d       = last_read;
    x_out_d      = ren ? in_data : x_out_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          radd_d  = '0;
        end
      end
      RUN: begin
        if (ren) begin
          if (last_read) begin
            radd_d  = '0;
            state_d = DRAIN;
          end else begin
            radd_d = radd_q + addressWidth'(1);
          end
        end
      end
      // The final pair is on the outputs during this single cycle.
      DRAIN: state_d = DONE;
      // start here chains the next pass without an IDLE bubble.
      DONE: begin
        if (start) begin
          state_d = RUN;
          radd_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      radd_d       = '0;
      pair_valid_d = 1'b0;
      last_d       = 1'b0;
    end

    // Status flags are registered alongside the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      radd_q       <= '0;
      pair_valid_q <= 1'b0;
      x_out_q      <= '0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      radd_q       <= radd_d;
      pair_valid_q <= pair_valid_d;
      x_out_q      <= x_out_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign radd       = radd_q;
  assign pair_valid = pair_valid_q;
  assign x_out      = x_out_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_weight_read_seq.sv
// ---------------------------------------------------------------------------
// tb_weight_read_seq
//   Drives two sequencers (numWeight=30 and numWeight=1) with the same
//   stimulus. A pass-level reference model predicts reads, pairs and done
//   pulses; predicted pairs/done pulses go into queues that a negedge monitor
//   pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_weight_read_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, in_valid;
  logic [15:0] in_data;

  logic        ren0, pv0, last0, busy0, done0;
  logic [4:0]  radd0;
  logic [15:0] x0;
  logic        ren1, pv1, last1, busy1, done1;
  logic [0:0]  radd1;
  logic [15:0] x1;

  always #5 clk = ~clk;

  weight_read_seq #(.numWeight(30), .dataWidth(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .ren(ren0), .radd(radd0),
    .pair_valid(pv0), .x_out(x0), .last(last0), .busy(busy0), .done(done0)
  );

  weight_read_seq #(.numWeight(1), .addressWidth(1), .dataWidth(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .ren(ren1), .radd(radd1),
    .pair_valid(pv1), .x_out(x1), .last(last1), .busy(busy1), .done(done1)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          lst;
  } pair_t;

  pair_t pq0[$];
  pair_t pq1[$];
  int    dq0[$];
  int    dq1[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: per pass, "reading" + number of reads so far, then a
  // two-cycle tail (final-pair cycle, done cycle).
  bit run_m[2];
  int idx_m[2];
  int tail_m[2];

  logic [15:0] ex0 = '0;
  logic [15:0] ex1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nw(input int k);
    return (k == 0) ? 30 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      run_m[k]  = 1'b0;
      idx_m[k]  = 0;
      tail_m[k] = 0;
    end
    pq0.delete(); pq1.delete(); dq0.delete(); dq1.delete();
  endtask

  // Advance the model across the coming clock edge, using current inputs.
  task automatic model_step(input int k);
    pair_t p;
    if (abort) begin
      run_m[k] = 1'b0; idx_m[k] = 0; tail_m[k] = 0;
    end else if (run_m[k]) begin
      if (in_valid) begin
        p.cyc  = cyc + 1;
        p.data = in_data;
        p.lst  = (idx_m[k] == nw(k) - 1);
        if (k == 0) pq0.push_back(p); else pq1.push_back(p);
        if (p.lst) begin
          run_m[k] = 1'b0; idx_m[k] = 0; tail_m[k] = 2;
        end else begin
          idx_m[k]++;
        end
      end
    end else if (tail_m[k] == 2) begin
      if (k == 0) dq0.push_back(cyc + 1); else dq1.push_back(cyc + 1);
      tail_m[k] = 1;
    end else begin
      tail_m[k] = 0;
      if (start) begin
        run_m[k] = 1'b1; idx_m[k] = 0;
      end
    end
  endtask

  // Apply inputs for the next edge, check combinational/state outputs, predict.
  task automatic drive(input bit s, input bit a, input bit v);
    start    = s;
    abort    = a;
    in_valid = a ? 1'b0 : v;
    in_data  = 16'($urandom);
    #1;
    chk("ren0",  {31'd0, ren0},  {31'd0, run_m[0] && in_valid});
    chk("radd0", {27'd0, radd0}, run_m[0] ? idx_m[0] : 0);
    chk("busy0", {31'd0, busy0}, {31'd0, run_m[0] || tail_m[0] > 0});
    chk("ren1",  {31'd0, ren1},  {31'd0, run_m[1] && in_valid});
    chk("radd1", {31'd0, radd1}, run_m[1] ? idx_m[1] : 0);
    chk("busy1", {31'd0, busy1}, {31'd0, run_m[1] || tail_m[1] > 0});
    model_step(0);
    model_step(1);
  endtask

  task automatic step(input bit s, input bit a, input bit v);
    @(posedge clk);
    #1;
    drive(s, a, v);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ren0"},  {31'd0, ren0},  0);
    chk({tag, "_radd0"}, {27'd0, radd0}, 0);
    chk({tag, "_pv0"},   {31'd0, pv0},   0);
    chk({tag, "_x0"},    {16'd0, x0},    0);
    chk({tag, "_last0"}, {31'd0, last0}, 0);
    chk({tag, "_busy0"}, {31'd0, busy0}, 0);
    chk({tag, "_done0"}, {31'd0, done0}, 0);
    chk({tag, "_pv1"},   {31'd0, pv1},   0);
    chk({tag, "_busy1"}, {31'd0, busy1}, 0);
    chk({tag, "_done1"}, {31'd0, done1}, 0);
  endtask

  // Monitor: compares presented pairs and done pulses against the queues.
  task automatic mon(input int k, input logic pv, input logic lst,
                     input logic [15:0] x, input logic dn);
    bit    ep, ed;
    pair_t p;
    logic [15:0] ex;
    ex = (k == 0) ? ex0 : ex1;
    if (!rst_n) ex = '0;
    if (k == 0) ep = (pq0.size() > 0) && (pq0[0].cyc == cyc);
    else        ep = (pq1.size() > 0) && (pq1[0].cyc == cyc);
    chk((k == 0) ? "pair_valid0" : "pair_valid1", {31'd0, pv}, {31'd0, ep});
    if (ep) begin
      if (k == 0) p = pq0.pop_front(); else p = pq1.pop_front();
      ex = p.data;
      chk((k == 0) ? "last0" : "last1", {31'd0, lst}, {31'd0, p.lst});
    end else begin
      chk((k == 0) ? "last0_idle" : "last1_idle", {31'd0, lst}, 0);
    end
    chk((k == 0) ? "x_out0" : "x_out1", {16'd0, x}, {16'd0, ex});
    if (k == 0) ed = (dq0.size() > 0) && (dq0[0] == cyc);
    else        ed = (dq1.size() > 0) && (dq1[0] == cyc);
    chk((k == 0) ? "done0" : "done1", {31'd0, dn}, {31'd0, ed});
    if (ed) begin
      if (k == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
    end
    if (k == 0) ex0 = ex; else ex1 = ex;
  endtask

  always @(negedge clk) begin
    mon(0, pv0, last0, x0, done0);
    mon(1, pv1, last1, x1, done1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");

    // Release, start accepted on the very first edge; continuous pass.
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 0, 1);
    repeat (34) step(0, 0, 1);

    // Stalls: in_valid toggling.
    step(1, 0, 0);
    for (int i = 0; i < 70; i++) step(0, 0, (i % 2) == 0);
    repeat (4) step(0, 0, 0);

    // Back-to-back: start held high (ignored in RUN/DRAIN, chains from DONE).
    step(1, 0, 1);
    repeat (70) step(1, 0, 1);
    repeat (5) step(0, 0, 0);

    // Abort after 12 reads, then a full pass.
    step(1, 0, 1);
    repeat (12) step(0, 0, 1);
    step(1, 1, 0);
    step(1, 0, 1);
    repeat (34) step(0, 0, 1);

    // Asynchronous reset mid-pass after 7 reads.
    step(1, 0, 1);
    repeat (7) step(0, 0, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_zero("async_rst");
    start = 1'b0; in_valid = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    check_zero("rst_held");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 0, 1);
    repeat (34) step(0, 0, 1);

    // Randomized traffic.
    repeat (3000) step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                       $urandom_range(0, 3) != 0);
    repeat (6) step(0, 0, 0);

    chk("pairq0_empty", pq0.size(), 0);
    chk("pairq1_empty", pq1.size(), 0);
    chk("doneq0_empty", dq0.size(), 0);
    chk("doneq1_empty", dq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
